// File: rtl/pattern_tx_pkg.sv
// pattern_tx_pkg: shared types, defaults and width helper for pattern_tx
//   DEF_WIDTH / DEF_REP_W : default pattern length and repeat-field width
//   state_t               : FSM states (GAP only with PATTERN_TX_GAP_EN)
//   LEN_W(w)              : width needed to hold a length 0..w
package pattern_tx_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;
`ifdef PATTERN_TX_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  function automatic int LEN_W(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/pattern_tx_if.sv
// pattern_tx_if: load/serial bus between a pattern source and pattern_tx
//   master : drives ld_valid, ld_data, ld_len, ld_reps, abort; sees ld_ready, out, out_valid, done
//   slave  : the transmitter side of the same signals
interface pattern_tx_if
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
);
  localparam int LW = LEN_W(WIDTH);
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_data;
  logic [LW-1:0]    ld_len;
  logic [REP_W-1:0] ld_reps;
  logic             abort;
  logic             out;
  logic             out_valid;
  logic             done;
  modport master (
    output ld_valid, ld_data, ld_len, ld_reps, abort,
    input  ld_ready, out, out_valid, done
  );
  modport slave (
    input  ld_valid, ld_data, ld_len, ld_reps, abort,
    output ld_ready, out, out_valid, done
  );
endinterface

// File: rtl/pattern_tx_ctr.sv
// pattern_tx_ctr: loadable down-counter with zero flag
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   ld, ld_val : load ld_val, takes priority over dec
//   dec        : decrement by one
//   cnt, zero  : current count and cnt == 0
module pattern_tx_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (dec) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: serialises a loaded pattern MSB-first, repeated ld_reps times
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pattern_tx_if slave (load handshake, abort, out/out_valid/done)
//   PATTERN_TX_GAP_EN : when defined, one idle GAP cycle separates repetitions
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  pattern_tx_if.slave    bus
);
  localparam int LW = LEN_W(WIDTH);
  localparam logic [LW-1:0] L1 = LW'(1);
  localparam logic [REP_W-1:0] R1 = REP_W'(1);
  state_t           state, state_d;
  logic [WIDTH-1:0] data_r, src, sh;
  logic [LW-1:0]    len_r, sel, b_val, b_cnt;
  logic [REP_W-1:0] r_val, r_cnt;
  logic             b_ld, b_dec, b_zero, r_ld, r_zero;
  logic             out_r, ov_r, done_r, out_d, ov_d, done_d, accept;
  assign accept        = state == IDLE && bus.ld_valid && !bus.abort;
  assign bus.ld_ready  = state == IDLE;
  assign bus.out       = out_r;
  assign bus.out_valid = ov_r;
  assign bus.done      = done_r;
  // bit index of the bit currently on out
  pattern_tx_ctr #(.W(LW)) u_bit (
    .clk(clk), .rst_n(rst_n), .ld(b_ld), .ld_val(b_val), .dec(b_dec), .cnt(b_cnt), .zero(b_zero)
  );
  // repetitions still to send after the current one; stepped by reload
  pattern_tx_ctr #(.W(REP_W)) u_rep (
    .clk(clk), .rst_n(rst_n), .ld(r_ld), .ld_val(r_val), .dec(1'b0), .cnt(r_cnt), .zero(r_zero)
  );
  always_comb begin
    state_d = state;
    ov_d    = 1'b0;
    done_d  = 1'b0;
    b_ld    = 1'b0;
    b_dec   = 1'b0;
    r_ld    = 1'b0;
    r_val   = r_cnt - R1;
    src     = data_r;
    sel     = len_r - L1;
    case (state)
      IDLE: begin
        src   = bus.ld_data;
        sel   = bus.ld_len - L1;
        r_val = (bus.ld_reps == '0) ? '0 : bus.ld_reps - R1;
        if (accept) begin
          done_d  = bus.ld_len == '0;
          ov_d    = !done_d;
          b_ld    = ov_d;
          r_ld    = ov_d;
          state_d = ov_d ? SHIFT : IDLE;
        end
      end
      SHIFT: begin
        if (bus.abort) state_d = IDLE;
        else if (!b_zero) begin
          b_dec = 1'b1;
          sel   = b_cnt - L1;
          ov_d  = 1'b1;
        end else if (r_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          r_ld = 1'b1;
`ifdef PATTERN_TX_GAP_EN
          state_d = GAP;
`else
          b_ld = 1'b1;
          ov_d = 1'b1;
`endif
        end
      end
`ifdef PATTERN_TX_GAP_EN
      GAP: begin
        state_d = bus.abort ? IDLE : SHIFT;
        b_ld    = !bus.abort;
        ov_d    = !bus.abort;
      end
`endif
      default: state_d = IDLE;
    endcase
    b_val = sel;
    sh    = src >> sel;
    out_d = ov_d & sh[0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      out_r  <= 1'b0;
      ov_r   <= 1'b0;
      done_r <= 1'b0;
      data_r <= '0;
      len_r  <= '0;
    end else begin
      state  <= state_d;
      out_r  <= out_d;
      ov_r   <= ov_d;
      done_r <= done_d;
      if (accept) begin
        data_r <= bus.ld_data;
        len_r  <= bus.ld_len;
      end
    end
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed self-checking bench for pattern_tx
module tb_pattern_tx;
  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  pattern_tx_if #(.WIDTH(8), .REP_W(4)) bus ();
  pattern_tx #(.WIDTH(8), .REP_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    bus.ld_data  = d;
    bus.ld_len   = l;
    bus.ld_reps  = r;
    bus.ld_valid = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready got=%b exp=1", bus.ld_ready); end
    n_chk++; if (bus.out !== 1'b0) begin n_fail++; $display("FAIL reset_out got=%b exp=0", bus.out); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask
  task automatic test_single;
    logic [3:0] exp_bits;
    logic [3:0] hist;
    exp_bits = 4'b1010;
    hist = 4'b0000;
    load(8'h0A, 4'd4, 4'd1);
    for (int c = 1; c <= 4; c++) begin
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out !== exp_bits[4-c]) begin n_fail++; $display("FAIL single_bit%0d got ov=%b out=%b exp ov=1 out=%b", c, bus.out_valid, bus.out, exp_bits[4-c]); end
      n_chk++; if (bus.ld_ready !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL single_busy%0d got ready=%b done=%b exp 0 0", c, bus.ld_ready, bus.done); end
      if (bus.out_valid) hist = {hist[2:0], bus.out};
      tick();
    end
    n_chk++; if (hist !== 4'b1010) begin n_fail++; $display("FAIL det_1010 got=%b exp=1010", hist); end
    n_chk++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 1'b0 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL single_done got done=%b ov=%b out=%b ready=%b exp 1 0 0 1", bus.done, bus.out_valid, bus.out, bus.ld_ready); end
    tick();
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse got=%b exp=0", bus.done); end
  endtask
  task automatic test_reps2;
    int n;
    int k;
    logic ev;
    logic eo;
`ifdef PATTERN_TX_GAP_EN
    n = 9;
`else
    n = 8;
`endif
    load(8'h0A, 4'd4, 4'd2);
    for (int c = 1; c <= n; c++) begin
      k = (n == 9 && c > 5) ? c - 1 : c;
      ev = !(n == 9 && c == 5);
      eo = ev & (k % 2 == 1);
      n_chk++; if (bus.out_valid !== ev || bus.out !== eo || bus.done !== 1'b0) begin n_fail++; $display("FAIL reps2_c%0d got ov=%b out=%b done=%b exp ov=%b out=%b done=0", c, bus.out_valid, bus.out, bus.done, ev, eo); end
      tick();
    end
    n_chk++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reps2_done got done=%b ov=%b exp 1 0", bus.done, bus.out_valid); end
    tick();
  endtask
  task automatic test_abort;
    logic [2:0] exp_bits;
    exp_bits = 3'b101;
    load(8'h0A, 4'd4, 4'd2);
    for (int c = 1; c <= 3; c++) begin
      n_chk++; if (bus.out !== exp_bits[3-c] || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pre%0d got ov=%b out=%b exp ov=1 out=%b", c, bus.out_valid, bus.out, exp_bits[3-c]); end
      if (c < 3) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.out !== 1'b0 || bus.done !== 1'b0 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL abort_stop got ov=%b out=%b done=%b ready=%b exp 0 0 0 1", bus.out_valid, bus.out, bus.done, bus.ld_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_quiet%0d got done=%b ov=%b exp 0 0", c, bus.done, bus.out_valid); end
    end
    bus.abort = 1'b1;
    load(8'h0A, 4'd4, 4'd1);
    bus.abort = 1'b0;
    n_chk++; if (bus.ld_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_wins got ready=%b ov=%b exp 1 0", bus.ld_ready, bus.out_valid); end
    load(8'h0A, 4'd4, 4'd1);
    n_chk++; if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_reload got ov=%b out=%b exp 1 1", bus.out_valid, bus.out); end
    repeat (4) tick();
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL abort_reload_done got=%b exp=1", bus.done); end
    tick();
  endtask
  task automatic test_len0;
    load(8'hFF, 4'd0, 4'd5);
    n_chk++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL len0_done got done=%b ov=%b ready=%b exp 1 0 1", bus.done, bus.out_valid, bus.ld_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_after%0d got done=%b ov=%b exp 0 0", c, bus.done, bus.out_valid); end
    end
  endtask
  task automatic test_reset_mid;
    load(8'hFF, 4'd8, 4'd1);
    tick();
    n_chk++; if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got ov=%b out=%b exp 1 1", bus.out_valid, bus.out); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got out=%b ov=%b done=%b ready=%b exp 0 0 0 1", bus.out, bus.out_valid, bus.done, bus.ld_ready); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after%0d got done=%b ov=%b ready=%b exp 0 0 1", c, bus.done, bus.out_valid, bus.ld_ready); end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] exp_bits;
    exp_bits = 4'b1010;
    bus.ld_data  = 8'h0A;
    bus.ld_len   = 4'd4;
    bus.ld_reps  = 4'd1;
    bus.ld_valid = 1'b1;
    tick();
    bus.ld_data = 8'h03;
    bus.ld_len  = 4'd2;
    for (int c = 1; c <= 4; c++) begin
      n_chk++; if (bus.out !== exp_bits[4-c] || bus.out_valid !== 1'b1 || bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first%0d got ov=%b out=%b ready=%b exp 1 %b 0", c, bus.out_valid, bus.out, bus.ld_ready, exp_bits[4-c]); end
      tick();
    end
    n_chk++; if (bus.done !== 1'b1 || bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got done=%b ready=%b exp 1 1", bus.done, bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      n_chk++; if (bus.out !== 1'b1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second%0d got ov=%b out=%b exp 1 1", c, bus.out_valid, bus.out); end
      tick();
    end
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got=%b exp=1", bus.done); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ov=%b done=%b exp 0 0", bus.out_valid, bus.done); end
  endtask
  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_len   = '0;
    bus.ld_reps  = '0;
    bus.abort    = 1'b0;
    test_reset();
    test_single();
    test_reps2();
    test_abort();
    test_len0();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8, maximum pattern length in bits.
REQ-002 Parameter REP_W, default 4, width of the repeat-count field.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ld_valid  input  1  load request; pattern fields are valid.
REQ-006 ld_ready  output  1  block can accept a load (high only in IDLE).
REQ-007 ld_data  input  WIDTH  pattern bits; bit ld_len-1 is sent first.
REQ-008 ld_len  input  $clog2(WIDTH+1)  number of pattern bits, 0..WIDTH.
REQ-009 ld_reps  input  REP_W  number of times the pattern is sent; 0 means 1.
REQ-010 abort  input  1  synchronous cancel of the current transfer.
REQ-011 out  output  1  serial bit stream; drives a sequence detector input.
REQ-012 out_valid  output  1  out carries a pattern bit this cycle.
REQ-013 done  output  1  one-cycle pulse after the last bit of the last repetition.

Function
REQ-014 FSM states are IDLE, SHIFT and GAP; GAP exists only with PATTERN_TX_GAP_EN.
REQ-015 A load is accepted on a posedge where ld_valid && ld_ready && !abort; ld_* are captured on that edge.
REQ-016 Accept with ld_len>=1: first bit ld_data[ld_len-1] appears on out with out_valid=1 in the cycle after accept; one bit per cycle, MSB-first, down to ld_data[0].
REQ-017 After bit 0, repeat from bit ld_len-1 until reps repetitions are sent; no dead cycle between repetitions without the macro.
REQ-018 Cycle after the final bit: out=0, out_valid=0, done=1, state IDLE, ld_ready=1; a new load may be accepted that cycle.
REQ-019 Accept with ld_len=0: no out_valid, done=1 in the next cycle.
REQ-020 Whenever out_valid=0, out SHALL be 0; outputs are registered, with no combinational path from inputs to out, out_valid or done.
REQ-021 ld_valid is ignored while not IDLE.
REQ-022 abort in SHIFT or GAP: next cycle IDLE, out=0, out_valid=0, no done pulse.
REQ-023 abort and ld_valid together in IDLE: abort wins, no accept.
REQ-024 Internal bit and repeat counters wrap-free: reps counted in REP_W bits, bit index in $clog2(WIDTH+1) bits.

Reset
REQ-025 On rst_n low, immediately: state IDLE, out=0, out_valid=0, done=0, ld_ready=1, counters cleared.
REQ-026 Reset asserted mid-transfer discards the transfer; no done after release.

Configuration
REQ-027 With PATTERN_TX_GAP_EN defined, one GAP cycle (out=0, out_valid=0) is inserted between consecutive repetitions, never after the last.
REQ-028 Without PATTERN_TX_GAP_EN, repetitions are back-to-back and no GAP state exists.

Structure
REQ-029 Package pattern_tx_pkg holds the state enum typedef, the default WIDTH and REP_W, and the LEN_W width function.
REQ-030 One sub-module, pattern_tx_ctr (loadable down-counter with zero flag), instantiated twice: once for bit index, once for repetitions.

Verification
REQ-031 ld_data=8'h0A, ld_len=4, ld_reps=1 -> out 1,0,1,0 in cycles 1-4 after accept, done in cycle 5; a chained det_1010 flags on bit 4.
REQ-032 Same pattern, ld_reps=2, macro off -> out 10101010 over 8 cycles, done in cycle 9; with macro -> 1010,gap,1010 over 9 cycles, done in cycle 10.
REQ-033 ld_reps=2, abort high in cycle 3 -> out_valid=0 from cycle 4, no done, ld_ready=1, next load accepted normally.
REQ-034 ld_len=0, ld_reps=5 -> out_valid never high, done in cycle 1.
REQ-035 rst_n pulsed low mid-transfer (cycle 2 of 8'hFF, ld_len=8) -> out=0 and out_valid=0 immediately, no done, ld_ready=1 after release.
REQ-036 ld_valid held high during a transfer -> no second accept until done cycle; back-to-back load accepted in the done cycle.
